// File: rtl/sap_pkg.sv
// Shared widths, opcode values and ALU select encoding for the SAP datapath and controller.
// Pure definitions: no logic, no latency, no flow control.
package sap_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_LDI = 4'd2;
    localparam logic [3:0] OP_STA = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_JMP = 4'd10;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [1:0] {
        ALU_ADDSUB = 2'b00,
        ALU_AND    = 2'b01,
        ALU_OR     = 2'b10,
        ALU_XOR    = 2'b11
    } alu_sel_e;
endpackage

// File: rtl/sap_alu.sv
// Combinational SAP ALU: add/sub with carry-out, bitwise logic ops and NOT of a.
// Zero latency; no flow control.
module sap_alu
    import sap_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         add_sub,
    input  logic [1:0]   sel,
    input  logic         xor_not,
    output logic [W-1:0] result,
    output logic         carry
);
    logic [W:0] sum;

    always_comb begin
        // Subtract is a + ~b + 1, so carry-out means "no borrow".
        if (add_sub)
            sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        else
            sum = {1'b0, a} + {1'b0, b};
        result = '0;
        carry  = 1'b0;
        if (xor_not) begin
            result = ~a;
        end else begin
            case (alu_sel_e'(sel))
                ALU_ADDSUB: begin
                    result = sum[W-1:0];
                    carry  = sum[W];
                end
                ALU_AND: result = a & b;
                ALU_OR:  result = a | b;
                ALU_XOR: result = a ^ b;
            endcase
        end
    end
endmodule

// File: rtl/sap_datapath.sv
// SAP datapath: registers, 16x8 RAM, ALU and shared bus driven by the controller's control word.
// Loads take effect one cycle after the control bit; halt and program-load freeze all state.
module sap_datapath
    import sap_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pc_inc,
    input  logic                     pc_out,
    input  logic                     jump,
    input  logic                     acc_in,
    input  logic                     acc_out,
    input  logic                     alu_out,
    input  logic                     add_sub,
    input  logic                     alu_1,
    input  logic                     alu_0,
    input  logic                     xor_not,
    input  logic                     mar_in,
    input  logic                     ram_in,
    input  logic                     ram_out,
    input  logic                     br_in,
    input  logic                     ir_in,
    input  logic                     ir_out,
    input  logic                     opr_in,
    input  logic                     hlt,
    input  logic                     load_en,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [DATA_W-1:0]        load_data,
    output logic [DATA_W-ADDR_W-1:0] msb_ireg,
    output logic                     halted,
    output logic [DATA_W-1:0]        out_reg,
    output logic [DATA_W-1:0]        bus,
    output logic                     zero_f,
    output logic                     carry_f,
    output logic                     bus_err
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] ram [2**ADDR_W];

    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              alu_en;
    logic [2:0]        drv_cnt;
    logic              multi_drv;
    logic              alu_drives;
    logic              frozen;

    sap_alu #(.W(DATA_W)) u_alu (
        .a       (acc),
        .b       (b_reg),
        .add_sub (add_sub),
        .sel     ({alu_1, alu_0}),
        .xor_not (xor_not),
        .result  (alu_res),
        .carry   (alu_carry)
    );

    assign alu_en     = alu_out | xor_not;
    assign drv_cnt    = 3'(pc_out) + 3'(ir_out) + 3'(acc_out) + 3'(ram_out) + 3'(alu_en);
    assign multi_drv  = (drv_cnt > 3'd1);
    assign alu_drives = alu_en & (drv_cnt == 3'd1);
    assign frozen     = load_en | halted;
    assign msb_ireg   = ir[DATA_W-1:ADDR_W];

    // A contended bus reads as zero rather than an OR of the drivers.
    always_comb begin
        bus = '0;
        if (drv_cnt == 3'd1)
            bus = ({DATA_W{pc_out}}  & DATA_W'(pc))
                | ({DATA_W{ir_out}}  & DATA_W'(ir[ADDR_W-1:0]))
                | ({DATA_W{acc_out}} & acc)
                | ({DATA_W{ram_out}} & ram[mar])
                | ({DATA_W{alu_en}}  & alu_res);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            mar     <= '0;
            ir      <= '0;
            acc     <= '0;
            b_reg   <= '0;
            out_reg <= '0;
            zero_f  <= 1'b0;
            carry_f <= 1'b0;
            halted  <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= multi_drv & ~frozen;
            if (!frozen) begin
                if (hlt)    halted  <= 1'b1;
                if (mar_in) mar     <= bus[ADDR_W-1:0];
                if (ir_in)  ir      <= bus;
                if (br_in)  b_reg   <= bus;
                if (acc_in) acc     <= bus;
                if (opr_in) out_reg <= bus;
                if (jump)
                    pc <= bus[ADDR_W-1:0];
                else if (pc_inc)
                    pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (acc_in && alu_drives) begin
                    zero_f  <= (alu_res == '0);
                    carry_f <= alu_carry;
                end
            end
        end
    end

    // RAM has no reset so a loaded program survives a controller reset.
    always_ff @(posedge clock) begin
        if (load_en)
            ram[load_addr] <= load_data;
        else if (!halted && !reset && ram_in)
            ram[mar] <= bus;
    end
endmodule

// File: doc/sap_datapath.md
Name: sap_datapath

Overview:
- Datapath responder for the SAP control unit; executes the control word issued each cycle by the controller.
- Holds PC, MAR, 16x8 RAM, IR, ACC, B register, ALU, output register and the shared 8-bit bus.
- Returns the opcode nibble (msb_ireg) and the halt status to the controller.
- Includes a program-load port for filling RAM before run.

Parameters:
- DATA_W, 8, bus/ACC/B/IR/RAM word width.
- ADDR_W, 4, PC/MAR width and operand field width; RAM depth = 2**ADDR_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pc_inc, pc_out, jump, acc_in, acc_out, alu_out, add_sub, alu_1, alu_0, xor_not, mar_in, ram_in, ram_out, br_in, ir_in, ir_out, opr_in, hlt  in  1 each  control word from controller.
- load_en  in  1  program-load mode; freezes datapath.
- load_addr  in  ADDR_W  RAM load address.
- load_data  in  DATA_W  RAM load data.
- msb_ireg  out  DATA_W-ADDR_W  IR[7:4], to controller.
- halted  out  1  sticky halt, to controller halt input.
- out_reg  out  DATA_W  output register.
- bus  out  DATA_W  current bus value (debug).
- zero_f, carry_f  out  1  flags.
- bus_err  out  1  registered multi-driver pulse.

Behaviour:
- Reset (async): PC, MAR, IR, ACC, B, out_reg, zero_f, carry_f, halted, bus_err = 0. RAM contents are not cleared.
- Bus (combinational):
  - Drivers: pc_out -> {0,PC}; ir_out -> {0,IR[3:0]}; acc_out -> ACC; ram_out -> RAM[MAR]; ALU result when alu_out or xor_not.
  - No driver -> bus = 0.
  - More than one driver -> bus = 0, and bus_err = 1 on the next cycle only.
- All loads sample the bus at the rising edge of the cycle in which the control signal is high; latency is 1 cycle.
  - mar_in: MAR <= bus[ADDR_W-1:0].
  - ir_in: IR <= bus.
  - br_in: B <= bus.
  - acc_in: ACC <= bus.
  - opr_in: out_reg <= bus.
  - ram_in: RAM[MAR] <= bus.
- PC:
  - jump: PC <= bus[ADDR_W-1:0].
  - Otherwise pc_inc: PC <= PC+1, wrapping 15 -> 0.
  - jump wins over pc_inc.
- ALU (combinational from ACC, B):
  - xor_not=1: ~ACC.
  - Else {alu_1,alu_0} = 00: ACC+B (add_sub=0) or ACC-B (add_sub=1, two's complement); 01 AND; 10 OR; 11 XOR.
  - Result is truncated to DATA_W bits. Carry = bit DATA_W of the 9-bit add, or of ACC + ~B + 1 for subtract. Carry = 0 for logic ops.
- Flags update only when acc_in and the ALU drives the bus: zero_f <= (result == 0), carry_f <= carry. All other cycles hold the flags.
- Same-cycle cases:
  - acc_in with acc_out: ACC reloads its own value.
  - ram_in with ram_out: RAM rewrites the same value.
  - mar_in with ram_out: the read uses the old MAR.
- Halt: hlt=1 sets halted at the edge. While halted, every register and RAM holds regardless of control inputs; only reset clears halted.
- Program load: while load_en=1, RAM[load_addr] <= load_data each cycle. All control inputs are ignored and all registers hold. load_en takes precedence over halted for RAM writes.
- msb_ireg = IR[7:4] continuously.

Decomposition:
- Shared package sap_pkg:
  - DATA_W/ADDR_W defaults.
  - Opcode constants: LDA=1, LDI=2, STA=3, ADD=4, SUB=5, AND=6, OR=7, XOR=8, NOT=9, JMP=10, OUT=14, HLT=15.
  - ALU select encoding (00 add/sub, 01 and, 10 or, 11 xor).
- One sub-module, sap_alu: combinational, with inputs a, b, add_sub, sel[1:0], xor_not and outputs result, carry. The top holds registers, RAM, bus mux and control.

Test Plan:
- Reset mid-run: with ACC=0x5A, PC=7, assert reset asynchronously between edges -> ACC, PC, out_reg and halted read 0 immediately; a RAM word loaded earlier is unchanged.
- Load RAM[0]=0x1E, RAM[14]=0x07, then pulse pc_out+mar_in, then ram_out+ir_in+pc_inc -> IR=0x1E, msb_ireg=1, PC=1.
- ACC=0xF0, B=0x20, add_sub=0, sel=00, alu_out+acc_in -> ACC=0x10, carry_f=1, zero_f=0. Then B=0x10 with add_sub=1 -> ACC=0x00, zero_f=1, carry_f=1.
- NOT: ACC=0x3C, xor_not+alu_1+alu_0+acc_in with alu_out low -> ACC=0xC3. XOR: ACC=0xFF, B=0x0F, sel=11 -> ACC=0xF0.
- Conflict and precedence:
  - acc_out+ram_out with opr_in -> out_reg=0x00 and bus_err high for exactly one cycle.
  - jump+pc_inc with ir_out and IR=0xA9 -> PC=9.
  - PC=15 with pc_inc -> PC=0.
- Halt freeze: hlt pulse, then acc_in with ir_out -> halted=1 and ACC unchanged for 10 cycles. load_en still writes RAM[3]=0x44, verified after reset.
